// File: rtl/regfile_read_sequencer.sv
// regfile_read_sequencer: drives one-hot enable/load strobes of a tri-state register array and captures its read buses.
// Optional build macro ZERO_REG_EN: index 0 is hardwired zero (no enable, no load, reads return 0).
module regfile_read_sequencer #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [AW-1:0]    rs1_idx,
    input  logic [AW-1:0]    rs2_idx,
    output logic             rd_rsp_valid,
    input  logic             rd_rsp_ready,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    output logic [NREGS-1:0] reg_out0_en,
    output logic [NREGS-1:0] reg_out1_en,
    output logic [NREGS-1:0] reg_load,
    output logic [XLEN-1:0]  reg_data_in,
    input  logic [XLEN-1:0]  bus0,
    input  logic [XLEN-1:0]  bus1,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, WRITE, DRIVE, RESP} state_t;
    state_t state_q, state_d;
    logic [NREGS-1:0] reg_out0_en_q, reg_out0_en_d, reg_out1_en_q, reg_out1_en_d, reg_load_q, reg_load_d;
    logic [XLEN-1:0] reg_data_in_q, reg_data_in_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic rd_rsp_valid_q, rd_rsp_valid_d;

    // Indices past the array shift out of the vector, so they select nothing.
    function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] idx);
`ifdef ZERO_REG_EN
        onehot = (idx == '0) ? '0 : ({{(NREGS-1){1'b0}}, 1'b1} << idx);
`else
        onehot = {{(NREGS-1){1'b0}}, 1'b1} << idx;
`endif
    endfunction

    // Next state and registered outputs; a read with no enable set captures 0 instead of the floating bus.
    always_comb begin
        state_d        = state_q;
        reg_load_d     = '0;
        reg_data_in_d  = '0;
        reg_out0_en_d  = '0;
        reg_out1_en_d  = '0;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        rd_rsp_valid_d = rd_rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    state_d       = WRITE;
                    reg_load_d    = onehot(wr_idx);
                    reg_data_in_d = wr_data;
                end else if (rd_req_valid) begin
                    state_d       = DRIVE;
                    reg_out0_en_d = onehot(rs1_idx);
                    reg_out1_en_d = onehot(rs2_idx);
                end
            end
            WRITE: state_d = IDLE;
            DRIVE: begin
                state_d        = RESP;
                rs1_data_d     = |reg_out0_en_q ? bus0 : '0;
                rs2_data_d     = |reg_out1_en_q ? bus1 : '0;
                rd_rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d        = rd_rsp_ready ? IDLE : RESP;
                rd_rsp_valid_d = !rd_rsp_ready;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops every bus drive immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            reg_load_q     <= '0;
            reg_data_in_q  <= '0;
            reg_out0_en_q  <= '0;
            reg_out1_en_q  <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            rd_rsp_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            reg_load_q     <= reg_load_d;
            reg_data_in_q  <= reg_data_in_d;
            reg_out0_en_q  <= reg_out0_en_d;
            reg_out1_en_q  <= reg_out1_en_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
        end
    end

    assign wr_ready     = state_q == IDLE;
    assign rd_req_ready = (state_q == IDLE) && !wr_valid;
    assign busy         = state_q != IDLE;
    assign reg_load     = reg_load_q;
    assign reg_data_in  = reg_data_in_q;
    assign reg_out0_en  = reg_out0_en_q;
    assign reg_out1_en  = reg_out1_en_q;
    assign rs1_data     = rs1_data_q;
    assign rs2_data     = rs2_data_q;
    assign rd_rsp_valid = rd_rsp_valid_q;
endmodule

// File: tb/tb_regfile_read_sequencer.sv
// tb_regfile_read_sequencer: random and directed stimulus against a transaction-level model of the sequencer.
module tb_regfile_read_sequencer;
    localparam int NREGS = 24;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rd_req_valid = 1'b0, rd_rsp_ready = 1'b0, wr_valid = 1'b0;
    logic [AW-1:0] rs1_idx = '0, rs2_idx = '0, wr_idx = '0;
    logic [XLEN-1:0] wr_data = '0;
    logic rd_req_ready, rd_rsp_valid, wr_ready, busy;
    logic [XLEN-1:0] rs1_data, rs2_data, reg_data_in, bus0, bus1;
    logic [NREGS-1:0] reg_out0_en, reg_out1_en, reg_load;
    int checks = 0, errors = 0;

    regfile_read_sequencer #(.NREGS(NREGS), .XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
        .reg_out0_en(reg_out0_en), .reg_out1_en(reg_out1_en), .reg_load(reg_load),
        .reg_data_in(reg_data_in), .bus0(bus0), .bus1(bus1), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register array environment: loads on the negedge, drives resolved buses; an undriven bus reads junk.
    logic [XLEN-1:0] regs [NREGS];
    always @(negedge clk)
        for (int i = 0; i < NREGS; i++)
            if (reg_load[i]) regs[i] <= reg_data_in;
    always_comb begin
        bus0 = '0;
        bus1 = '0;
        for (int j = 0; j < NREGS; j++) begin
            if (reg_out0_en[j]) bus0 |= regs[j];
            if (reg_out1_en[j]) bus1 |= regs[j];
        end
        if (reg_out0_en == '0) bus0 = 32'hBADC0FFE;
        if (reg_out1_en == '0) bus1 = 32'hBADC0FFE;
    end

    // Transaction-level model: architectural register contents plus outstanding-transaction bookkeeping.
    logic [XLEN-1:0] mem [NREGS];
    bit wr_pend = 0;
    int rd_stage = 0;
    bit e_valid = 0;
    logic [NREGS-1:0] e_load = '0, e_en0 = '0, e_en1 = '0;
    logic [XLEN-1:0] e_din = '0, e_d1 = '0, e_d2 = '0, r1 = '0, r2 = '0;

    function automatic bit ok_idx(input int i);
        return i < NREGS && !(ZR && i == 0);
    endfunction

    function automatic logic [NREGS-1:0] oh(input int i);
        logic [NREGS-1:0] v = '0;
        if (ok_idx(i)) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] rdv(input int i);
        if (ok_idx(i)) return mem[i];
        return '0;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", busy, !(wr_pend == 0 && rd_stage == 0));
            chk("wr_ready", wr_ready, wr_pend == 0 && rd_stage == 0);
            chk("rd_req_ready", rd_req_ready, wr_pend == 0 && rd_stage == 0 && !wr_valid);
            chk("reg_load", reg_load, e_load);
            chk("reg_data_in", reg_data_in, e_din);
            chk("reg_out0_en", reg_out0_en, e_en0);
            chk("reg_out1_en", reg_out1_en, e_en1);
            chk("rd_rsp_valid", rd_rsp_valid, e_valid);
            if (e_valid) begin
                chk("rs1_data", rs1_data, e_d1);
                chk("rs2_data", rs2_data, e_d2);
            end
        end
    end

    // Applies one cycle of inputs, advances the model across the coming posedge, returns at negedge+1.
    task automatic step(input bit wv, input int wi, input logic [31:0] wd,
                        input bit rv, input int i1, input int i2, input bit rr);
        wr_valid = wv; wr_idx = wi[AW-1:0]; wr_data = wd;
        rd_req_valid = rv; rs1_idx = i1[AW-1:0]; rs2_idx = i2[AW-1:0]; rd_rsp_ready = rr;
        e_load = '0; e_din = '0; e_en0 = '0; e_en1 = '0;
        if (!wr_pend && rd_stage == 0) begin
            if (wv) begin
                e_load = oh(wi);
                e_din = wd;
                if (ok_idx(wi)) mem[wi] = wd;
                wr_pend = 1;
            end else if (rv) begin
                e_en0 = oh(i1);
                e_en1 = oh(i2);
                r1 = rdv(i1);
                r2 = rdv(i2);
                rd_stage = 1;
            end
        end else if (wr_pend) wr_pend = 0;
        else if (rd_stage == 1) begin
            rd_stage = 2; e_valid = 1; e_d1 = r1; e_d2 = r2;
        end else if (rr) begin
            rd_stage = 0; e_valid = 0;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            regs[i] = 32'h01010101 * i;
            mem[i] = 32'h01010101 * i;
        end
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rd_rsp_valid, 0);
        chk("rst_rs1", rs1_data, 0);
        chk("rst_load", reg_load, 0);
        chk("rst_wr_ready", wr_ready, 1);
        // write 5 then read 5/5
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 1, 5, 5, 0);
        chk("t2_en0", reg_out0_en, 24'h20);
        chk("t2_en1", reg_out1_en, 24'h20);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t2_valid", rd_rsp_valid, 1);
        chk("t2_rs1", rs1_data, 32'hDEADBEEF);
        chk("t2_rs2", rs2_data, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 1);
        // same-cycle write and read: write wins, read sees new value
        step(1, 7, 32'h1234, 1, 7, 7, 0);
        chk("t3_load", reg_load, 24'h80);
        step(0, 0, 0, 1, 7, 7, 0);
        step(0, 0, 0, 1, 7, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t3_rs1", rs1_data, 32'h1234);
        chk("t3_rs2", rs2_data, 32'h1234);
        // response back-pressure with requests pending
        for (int k = 0; k < 3; k++) begin
            step(1, 3, 32'hAAAA, 1, 2, 2, 0);
            chk("t4_valid", rd_rsp_valid, 1);
            chk("t4_rs1", rs1_data, 32'h1234);
            chk("t4_rd_ready", rd_req_ready, 0);
            chk("t4_wr_ready", wr_ready, 0);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        // index 0 behaviour
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 1, 0, 0, 0);
        chk("t5_en0_bit0", reg_out0_en[0], ZR ? 1'b0 : 1'b1);
        idle();
        chk("t5_rs1", rs1_data, ZR ? 32'h0 : 32'hFFFFFFFF);
        step(0, 0, 0, 0, 0, 0, 1);
        // out-of-range index
        step(0, 0, 0, 1, 30, 3, 0);
        chk("t6_en0", reg_out0_en, 0);
        chk("t6_en1", reg_out1_en, 24'h8);
        idle();
        chk("t6_rs1", rs1_data, 0);
        chk("t6_rs2", rs2_data, 32'h03030303);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 30, 32'h5555, 0, 0, 0, 0);
        chk("t6_load", reg_load, 0);
        chk("t6_busy", busy, 1);
        idle();
        // asynchronous reset while driving the buses
        step(0, 0, 0, 1, 5, 7, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_en0", reg_out0_en, 0);
        chk("t1_en1", reg_out1_en, 0);
        chk("t1_busy", busy, 0);
        chk("t1_valid", rd_rsp_valid, 0);
        rd_req_valid = 0; wr_valid = 0; rd_rsp_ready = 0;
        wr_pend = 0; rd_stage = 0; e_valid = 0;
        e_load = '0; e_din = '0; e_en0 = '0; e_en1 = '0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3000)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 31), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 1) == 1);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
